// File: rtl/cam_capture_pack.sv
// cam_capture_pack: camera capture front-end.
// Packs DATA_W-bit sensor bytes into BYTES_PER_PIX-byte pixels, crops them to a
// runtime window latched at each frame start, and writes them into a pixel FIFO.
// The frame state machine only starts capture at a clean frame boundary. It
// abandons a frame that hits a full FIFO, and supports continuous and
// single-shot capture.
//
// Ports (all synchronous to pclk):
//   pclk, rst                    clock, synchronous active-high reset
//   capture_en, cfg_single       capture enable, single-shot mode
//   cfg_x_start/end, cfg_y_*     inclusive crop window (applied per frame)
//   err_clr                      clears sticky error flags
//   vsync, href, data            sensor interface (vsync high = blanking)
//   fifo_full                    downstream FIFO full
//   fifo_wr_en, fifo_din         FIFO write strobe and packed pixel
//   frame_start, frame_done      one-cycle frame pulses (done = good frame only)
//   frame_count, drop_count      good frames / overflow-aborted frames (sat 255)
//   busy                         state machine not idle
//   err_overflow, err_partial    sticky error flags
module cam_capture_pack #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned BYTES_PER_PIX = 2,
   parameter int unsigned SWAP_BYTES    = 0,
   parameter int unsigned HCNT_W        = 12,
   parameter int unsigned VCNT_W        = 11,
   parameter int unsigned FCNT_W        = 16
) (
   input  logic                            pclk,
   input  logic                            rst,
   input  logic                            capture_en,
   input  logic                            cfg_single,
   input  logic [HCNT_W-1:0]               cfg_x_start,
   input  logic [HCNT_W-1:0]               cfg_x_end,
   input  logic [VCNT_W-1:0]               cfg_y_start,
   input  logic [VCNT_W-1:0]               cfg_y_end,
   input  logic                            err_clr,
   input  logic                            vsync,
   input  logic                            href,
   input  logic [DATA_W-1:0]               data,
   input  logic                            fifo_full,
   output logic                            fifo_wr_en,
   output logic [DATA_W*BYTES_PER_PIX-1:0] fifo_din,
   output logic                            frame_start,
   output logic                            frame_done,
   output logic [FCNT_W-1:0]               frame_count,
   output logic [7:0]                      drop_count,
   output logic                            busy,
   output logic                            err_overflow,
   output logic                            err_partial
);

   localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
   localparam int unsigned PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTES_PER_PIX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VS,
      S_SYNC,
      S_ACTIVE,
      S_DROP
   } state_e;

   state_e state_q, state_d;

   // input stage and edge history
   logic              vs_q, hr_q, vs_p_q, hr_p_q;
   logic [DATA_W-1:0] dat_q;

   logic [PH_W-1:0]   phase_q, phase_d;
   logic [PIX_W-1:0]  pack_q, pack_d;
   logic [HCNT_W-1:0] x_q, x_d, xs_q, xs_d, xe_q, xe_d;
   logic [VCNT_W-1:0] y_q, y_d, ys_q, ys_d, ye_q, ye_d;
   logic              single_done_q, single_done_d;

   // write / done pipeline: decision -> pending -> output
   logic              wr_p_q, wr_d;
   logic [PIX_W-1:0]  pix_p_q, pix_d;
   logic              start_d;
   logic              done_p_q, done_p2_q, done_d;
   logic [7:0]        drop_q, drop_d;
   logic              ovf_set, part_set;

   logic                 fifo_wr_en_q, frame_start_q, frame_done_q, busy_q;
   logic [PIX_W-1:0]     fifo_din_q;
   logic [FCNT_W-1:0]    frame_count_q;
   logic                 err_ovf_q, err_part_q;

   logic              vs_rise_c, vs_fall_c, hr_fall_c, in_win_c;
   logic [PIX_W-1:0]  pack_shift_c, pix_c;

   assign vs_rise_c = vs_q & ~vs_p_q;
   assign vs_fall_c = ~vs_q & vs_p_q;
   assign hr_fall_c = ~hr_q & hr_p_q;
   assign in_win_c  = (x_q >= xs_q) && (x_q <= xe_q) && (y_q >= ys_q) && (y_q <= ye_q);

   // shift the new byte in; the earliest byte ends up in the MSBs
   assign pack_shift_c = PIX_W'({pack_q, dat_q});

   // optional byte reversal so the first byte lands in the LSBs
   always_comb begin
      pix_c = pack_shift_c;
      if (SWAP_BYTES != 0) begin
         for (int unsigned b = 0; b < BYTES_PER_PIX; b++) begin
            pix_c[b*DATA_W +: DATA_W] = pack_shift_c[(BYTES_PER_PIX-1-b)*DATA_W +: DATA_W];
         end
      end
   end

   // next-state and datapath decisions
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      pack_d        = pack_q;
      x_d           = x_q;
      y_d           = y_q;
      xs_d          = xs_q;
      xe_d          = xe_q;
      ys_d          = ys_q;
      ye_d          = ye_q;
      single_done_d = single_done_q & capture_en;
      wr_d          = 1'b0;
      pix_d         = pix_p_q;
      start_d       = 1'b0;
      done_d        = 1'b0;
      drop_d        = drop_q;
      ovf_set       = 1'b0;
      part_set      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // a finished single shot waits for capture_en to drop before re-arming
            if (capture_en && !single_done_q) state_d = S_WAIT_VS;
         end
         S_WAIT_VS: begin
            if (!capture_en)    state_d = S_IDLE;
            else if (vs_rise_c) state_d = S_SYNC;
         end
         S_SYNC: begin
            if (!capture_en) begin
               state_d = S_IDLE;
            end else if (vs_fall_c) begin
               state_d = S_ACTIVE;
               start_d = 1'b1;
               phase_d = '0;
               pack_d  = '0;
               x_d     = '0;
               y_d     = '0;
               xs_d    = cfg_x_start;
               xe_d    = cfg_x_end;
               ys_d    = cfg_y_start;
               ye_d    = cfg_y_end;
            end
         end
         S_ACTIVE: begin
            if (hr_q) begin
               pack_d = pack_shift_c;
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  x_d     = (x_q == {HCNT_W{1'b1}}) ? x_q : x_q + HCNT_W'(1);
                  if (in_win_c) begin
                     if (fifo_full) begin
                        ovf_set = 1'b1;
                     end else begin
                        wr_d  = 1'b1;
                        pix_d = pix_c;
                     end
                  end
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end else if (hr_fall_c) begin
               if (phase_q != '0) part_set = 1'b1;
               phase_d = '0;
               x_d     = '0;
               y_d     = (y_q == {VCNT_W{1'b1}}) ? y_q : y_q + VCNT_W'(1);
            end

            if (vs_rise_c) begin
               if (ovf_set) begin
                  // overflow on the closing edge: the frame is already over
                  drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                  state_d = capture_en ? S_SYNC : S_IDLE;
               end else begin
                  done_d        = 1'b1;
                  single_done_d = cfg_single & capture_en;
                  state_d       = (cfg_single || !capture_en) ? S_IDLE : S_SYNC;
               end
            end else if (ovf_set) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (vs_rise_c) begin
               drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
               state_d = capture_en ? S_SYNC : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge pclk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // datapath and output registers
   always_ff @(posedge pclk) begin
      if (rst) begin
         vs_q          <= 1'b0;
         hr_q          <= 1'b0;
         vs_p_q        <= 1'b0;
         hr_p_q        <= 1'b0;
         dat_q         <= '0;
         phase_q       <= '0;
         pack_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         xs_q          <= '0;
         xe_q          <= '0;
         ys_q          <= '0;
         ye_q          <= '0;
         single_done_q <= 1'b0;
         wr_p_q        <= 1'b0;
         pix_p_q       <= '0;
         done_p_q      <= 1'b0;
         done_p2_q     <= 1'b0;
         drop_q        <= '0;
         fifo_wr_en_q  <= 1'b0;
         fifo_din_q    <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         busy_q        <= 1'b0;
         err_ovf_q     <= 1'b0;
         err_part_q    <= 1'b0;
      end else begin
         vs_q          <= vsync;
         hr_q          <= href;
         dat_q         <= data;
         vs_p_q        <= vs_q;
         hr_p_q        <= hr_q;
         phase_q       <= phase_d;
         pack_q        <= pack_d;
         x_q           <= x_d;
         y_q           <= y_d;
         xs_q          <= xs_d;
         xe_q          <= xe_d;
         ys_q          <= ys_d;
         ye_q          <= ye_d;
         single_done_q <= single_done_d;
         wr_p_q        <= wr_d;
         pix_p_q       <= pix_d;
         drop_q        <= drop_d;
         fifo_wr_en_q  <= wr_p_q;
         if (wr_p_q) fifo_din_q <= pix_p_q;
         // frame_done trails the last possible write of the frame by one cycle
         done_p_q      <= done_d;
         done_p2_q     <= done_p_q;
         frame_done_q  <= done_p2_q;
         if (done_p2_q) frame_count_q <= frame_count_q + FCNT_W'(1);
         frame_start_q <= start_d;
         busy_q        <= (state_d != S_IDLE);
         // a set in the same cycle as err_clr wins
         err_ovf_q     <= ovf_set  | (err_ovf_q  & ~err_clr);
         err_part_q    <= part_set | (err_part_q & ~err_clr);
      end
   end

   assign fifo_wr_en   = fifo_wr_en_q;
   assign fifo_din     = fifo_din_q;
   assign frame_start  = frame_start_q;
   assign frame_done   = frame_done_q;
   assign frame_count  = frame_count_q;
   assign drop_count   = drop_q;
   assign busy         = busy_q;
   assign err_overflow = err_ovf_q;
   assign err_partial  = err_part_q;

endmodule

// File: tb/tb_cam_capture_pack.sv
// Directed testbench for cam_capture_pack (DATA_W=8, BYTES_PER_PIX=2, no swap).
// Frames are 4 pixels x 3 lines; byte i of line y is 0x10 + 2*y + i.
module tb_cam_capture_pack;

   localparam int unsigned W = 4;

   logic        pclk = 1'b0;
   logic        rst;
   logic        capture_en, cfg_single, err_clr;
   logic [11:0] cfg_x_start, cfg_x_end;
   logic [10:0] cfg_y_start, cfg_y_end;
   logic        vsync, href, fifo_full;
   logic [7:0]  data;
   logic        fifo_wr_en, frame_start, frame_done, busy, err_overflow, err_partial;
   logic [15:0] fifo_din, frame_count;
   logic [7:0]  drop_count;

   cam_capture_pack dut (
      .pclk        (pclk),
      .rst         (rst),
      .capture_en  (capture_en),
      .cfg_single  (cfg_single),
      .cfg_x_start (cfg_x_start),
      .cfg_x_end   (cfg_x_end),
      .cfg_y_start (cfg_y_start),
      .cfg_y_end   (cfg_y_end),
      .err_clr     (err_clr),
      .vsync       (vsync),
      .href        (href),
      .data        (data),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .drop_count  (drop_count),
      .busy        (busy),
      .err_overflow(err_overflow),
      .err_partial (err_partial)
   );

   always #5 pclk = ~pclk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_px00 = 0;
   int first_cyc = 0;
   int n_start = 0;
   int n_done  = 0;
   logic [15:0] wr_q[$];

   always @(posedge pclk) cyc <= cyc + 1;

   // output monitor, sampled on the falling edge
   always @(negedge pclk) begin
      if (fifo_wr_en) begin
         if (wr_q.size() == 0) first_cyc = cyc;
         wr_q.push_back(fifo_din);
      end
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] q_at(input int idx);
      if (idx < wr_q.size()) return wr_q[idx];
      return 16'h0;
   endfunction

   task automatic clear_mon();
      @(posedge pclk);
      #1;
      wr_q.delete();
      n_start = 0;
      n_done  = 0;
   endtask

   task automatic set_win(input int xs, input int xe, input int ys, input int ye);
      cfg_x_start = 12'(xs);
      cfg_x_end   = 12'(xe);
      cfg_y_start = 11'(ys);
      cfg_y_end   = 11'(ye);
   endtask

   task automatic pulse_err_clr();
      @(negedge pclk);
      err_clr = 1'b1;
      @(negedge pclk);
      err_clr = 1'b0;
   endtask

   // vsync rise (closes any previous frame), blanking, fall, then h lines.
   // full_px: linear pixel index at which fifo_full rises (held to frame end).
   // len0: byte count of line 0 (-1 = full line). en_line: line at which
   // capture_en is raised. rst_px: pixel during which rst is pulsed.
   task automatic send_frame(input int h, input int full_px, input int len0,
                             input int en_line, input int rst_px);
      int nb, px, wr_snap;
      @(negedge pclk);
      vsync = 1'b1;
      href  = 1'b0;
      repeat (3) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
      for (int y = 0; y < h; y++) begin
         if (y == en_line) capture_en = 1'b1;
         nb = (y == 0 && len0 >= 0) ? len0 : int'(W) * 2;
         for (int i = 0; i < nb; i++) begin
            href = 1'b1;
            data = 8'(16 + 2 * y + i);
            px   = y * int'(W) + i / 2;
            if (px == full_px && (i % 2) == 1) fifo_full = 1'b1;
            if (y == 0 && i == 1) t_px00 = cyc + 1;
            if (px == rst_px && (i % 2) == 1) begin
               rst = 1'b1;
               @(posedge pclk);
               #1;
               chk("rst_wr_en",   32'(fifo_wr_en),   32'd0);
               chk("rst_busy",    32'(busy),         32'd0);
               chk("rst_fcount",  32'(frame_count),  32'd0);
               chk("rst_dcount",  32'(drop_count),   32'd0);
               chk("rst_ovf",     32'(err_overflow), 32'd0);
               chk("rst_partial", 32'(err_partial),  32'd0);
               rst = 1'b0;
               wr_snap = wr_q.size();
               @(negedge pclk);
            end else begin
               @(negedge pclk);
            end
         end
         href = 1'b0;
         data = 8'hEE;
         repeat (3) @(negedge pclk);
      end
      fifo_full = 1'b0;
      if (rst_px >= 0) begin
         repeat (4) @(negedge pclk);
         chk("rst_no_writes_after", 32'(wr_q.size()), 32'(wr_snap));
      end
   endtask

   // vsync rise ending the last frame, flush, then back to low
   task automatic close_frame();
      @(negedge pclk);
      vsync = 1'b1;
      repeat (10) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   typedef struct {
      int          xs, xe, ys, ye;
      int          full_px;
      int          exp_n;
      logic [15:0] exp_first, exp_last;
      int          exp_done;
      int          exp_drop;
      logic        exp_ovf;
      logic        chk_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] fc0, dfc;
      logic [7:0]  dc0, ddc;
      int          snap;

      vecs[0] = '{1, 2, 1, 1, -1, 2,  16'h1415, 16'h1617, 1, 0, 1'b0, 1'b0};
      vecs[1] = '{0, 3, 0, 2, -1, 12, 16'h1011, 16'h1A1B, 1, 0, 1'b0, 1'b1};
      vecs[2] = '{2, 1, 0, 2, -1, 0,  16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0};
      vecs[3] = '{0, 3, 2, 0, -1, 0,  16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0};
      vecs[4] = '{0, 3, 0, 2, 2,  2,  16'h1011, 16'h1213, 0, 1, 1'b1, 1'b1};
      vecs[5] = '{3, 3, 2, 2, -1, 1,  16'h1A1B, 16'h1A1B, 1, 0, 1'b0, 1'b0};
      vecs[6] = '{0, 0, 0, 0, -1, 1,  16'h1011, 16'h1011, 1, 0, 1'b0, 1'b1};

      rst = 1'b1;
      capture_en = 1'b0;
      cfg_single = 1'b0;
      err_clr = 1'b0;
      vsync = 1'b0;
      href = 1'b0;
      data = 8'h00;
      fifo_full = 1'b0;
      set_win(0, 3, 0, 2);
      repeat (3) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
      chk("reset_wr_en",   32'(fifo_wr_en),   32'd0);
      chk("reset_din",     32'(fifo_din),     32'd0);
      chk("reset_fstart",  32'(frame_start),  32'd0);
      chk("reset_fdone",   32'(frame_done),   32'd0);
      chk("reset_fcount",  32'(frame_count),  32'd0);
      chk("reset_dcount",  32'(drop_count),   32'd0);
      chk("reset_busy",    32'(busy),         32'd0);
      chk("reset_ovf",     32'(err_overflow), 32'd0);
      chk("reset_partial", 32'(err_partial),  32'd0);

      // single-frame vectors; capture_en drops before the closing vsync edge
      for (int k = 0; k < 7; k++) begin
         pulse_err_clr();
         set_win(vecs[k].xs, vecs[k].xe, vecs[k].ys, vecs[k].ye);
         capture_en = 1'b1;
         fc0 = frame_count;
         dc0 = drop_count;
         clear_mon();
         send_frame(3, vecs[k].full_px, -1, -1, -1);
         capture_en = 1'b0;
         close_frame();
         dfc = frame_count - fc0;
         ddc = drop_count - dc0;
         chk($sformatf("v%0d_nwrites", k), 32'(wr_q.size()),  32'(vecs[k].exp_n));
         chk($sformatf("v%0d_first",   k), 32'(q_at(0)),       32'(vecs[k].exp_first));
         chk($sformatf("v%0d_last",    k), 32'(q_at(vecs[k].exp_n - 1)), 32'(vecs[k].exp_last));
         chk($sformatf("v%0d_nstart",  k), 32'(n_start),       32'd1);
         chk($sformatf("v%0d_ndone",   k), 32'(n_done),        32'(vecs[k].exp_done));
         chk($sformatf("v%0d_fcount",  k), 32'(dfc),           32'(vecs[k].exp_done));
         chk($sformatf("v%0d_dcount",  k), 32'(ddc),           32'(vecs[k].exp_drop));
         chk($sformatf("v%0d_ovf",     k), 32'(err_overflow),  32'(vecs[k].exp_ovf));
         chk($sformatf("v%0d_busy",    k), 32'(busy),          32'd0);
         if (vecs[k].chk_lat)
            chk($sformatf("v%0d_latency", k), 32'(first_cyc - t_px00), 32'd2);
      end

      // enable raised mid-frame: nothing until the next full frame
      pulse_err_clr();
      set_win(0, 3, 0, 2);
      clear_mon();
      send_frame(3, -1, -1, 1, -1);
      chk("miden_no_early_writes", 32'(wr_q.size()), 32'd0);
      send_frame(3, -1, -1, -1, -1);
      capture_en = 1'b0;
      close_frame();
      chk("miden_nwrites", 32'(wr_q.size()), 32'd12);
      chk("miden_first",   32'(q_at(0)),     32'h1011);
      chk("miden_nstart",  32'(n_start),     32'd1);
      chk("miden_ndone",   32'(n_done),      32'd1);

      // partial pixel on line 0, line 1 must restart at byte phase 0
      set_win(0, 3, 0, 2);
      capture_en = 1'b1;
      clear_mon();
      send_frame(2, -1, 3, -1, -1);
      capture_en = 1'b0;
      close_frame();
      chk("partial_nwrites", 32'(wr_q.size()), 32'd5);
      chk("partial_w0",      32'(q_at(0)),     32'h1011);
      chk("partial_w1",      32'(q_at(1)),     32'h1213);
      chk("partial_flag",    32'(err_partial), 32'd1);
      chk("partial_ndone",   32'(n_done),      32'd1);
      pulse_err_clr();
      @(negedge pclk);
      chk("partial_cleared", 32'(err_partial), 32'd0);

      // single-shot with capture_en held: only the first frame is taken
      cfg_single = 1'b1;
      capture_en = 1'b1;
      fc0 = frame_count;
      clear_mon();
      send_frame(3, -1, -1, -1, -1);
      send_frame(3, -1, -1, -1, -1);
      chk("single_busy_after_first", 32'(busy), 32'd0);
      send_frame(3, -1, -1, -1, -1);
      close_frame();
      dfc = frame_count - fc0;
      chk("single_nwrites", 32'(wr_q.size()), 32'd12);
      chk("single_ndone",   32'(n_done),      32'd1);
      chk("single_fcount",  32'(dfc),         32'd1);
      chk("single_nstart",  32'(n_start),     32'd1);
      chk("single_busy",    32'(busy),        32'd0);
      capture_en = 1'b0;
      cfg_single = 1'b0;
      repeat (3) @(negedge pclk);

      // overflow then a full recovery frame in continuous mode
      pulse_err_clr();
      set_win(0, 3, 0, 2);
      capture_en = 1'b1;
      fc0 = frame_count;
      dc0 = drop_count;
      clear_mon();
      send_frame(3, 2, -1, -1, -1);
      send_frame(3, -1, -1, -1, -1);
      capture_en = 1'b0;
      close_frame();
      dfc = frame_count - fc0;
      ddc = drop_count - dc0;
      chk("ovfrec_nwrites", 32'(wr_q.size()),  32'd14);
      chk("ovfrec_second",  32'(q_at(2)),      32'h1011);
      chk("ovfrec_last",    32'(q_at(13)),     32'h1A1B);
      chk("ovfrec_ndone",   32'(n_done),       32'd1);
      chk("ovfrec_fcount",  32'(dfc),          32'd1);
      chk("ovfrec_dcount",  32'(ddc),          32'd1);
      chk("ovfrec_ovf",     32'(err_overflow), 32'd1);

      // reset mid-line while streaming
      capture_en = 1'b1;
      clear_mon();
      snap = 0;
      send_frame(3, -1, -1, -1, 5);
      capture_en = 1'b0;
      close_frame();
      chk("rst_fcount_end", 32'(frame_count), 32'(snap));
      chk("rst_ndone_end",  32'(n_done),      32'(snap));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
